context_update_stage: RTL
=========================

CONTEXT_UPDATE_STAGE -- requirements
Module: context_update_stage

Interface
REQ-001 The block SHALL have parameter NUM_CTX, default 365, the number of regular-mode contexts.
REQ-002 The block SHALL have parameter ERR_W, default 8, the width of the signed prediction error.
REQ-003 The block SHALL have parameter A_W, default 16, the width of accumulator A.
REQ-004 The block SHALL have parameter N_W, default 7, the width of counter N.
REQ-005 The block SHALL have parameter RESET_N, default 64, the N value that triggers halving.
REQ-006 The block SHALL have parameter A_INIT, default 4, the initial A value.
REQ-007 The block SHALL have input clk, 1 bit: the clock.
REQ-008 The block SHALL have input reset, 1 bit: reset, synchronous, active-high, sampled on clk.
REQ-009 The block SHALL have input in_valid, 1 bit: update request present.
REQ-010 The block SHALL have output in_ready, 1 bit: request accepted when in_valid and in_ready are both 1.
REQ-011 The block SHALL have input in_q, 9 bits: context index, 0..NUM_CTX-1.
REQ-012 The block SHALL have input in_err, ERR_W bits, signed: Errval.
REQ-013 The block SHALL have output out_valid, 1 bit: result valid, asserted for one cycle per request.
REQ-014 The block SHALL have output out_q, 9 bits: echoed context index.
REQ-015 The block SHALL have output out_k, 5 bits: Golomb k computed from pre-update A and N.
REQ-016 The block SHALL have outputs out_a (A_W bits), out_b (ERR_W+N_W bits, signed), out_c (8 bits, signed) and out_n (N_W bits): post-update context values.

Function
REQ-017 The block SHALL hold A, B, C and N for NUM_CTX contexts in internal storage.
REQ-018 The FSM SHALL have states INIT and RUN: INIT writes A=A_INIT, B=0, C=0, N=1 to one address per cycle, 0..NUM_CTX-1, and moves to RUN after the last address; in_ready SHALL be 1 only in RUN.
REQ-019 Pipeline S1 SHALL register the stored values of in_q on acceptance; S2 SHALL compute the update, write it back and register the outputs; out_valid SHALL rise 2 cycles after acceptance.
REQ-020 In RUN, the block SHALL accept one request per cycle with no bubbles; there is no output backpressure.
REQ-021 If S1 reads the context being written by S2 in the same cycle, the block SHALL forward the S2 result so that back-to-back same-context updates see updated values.
REQ-022 out_k SHALL be the smallest k in 0..A_W such that (N << k) >= A, using pre-update values.
REQ-023 The update SHALL be computed as: B += Err; A += |Err|; if N == RESET_N then A >>= 1, B >>= 1 (arithmetic), N >>= 1; then N += 1.
REQ-024 Bias correction SHALL then use the new N: if B <= -N, C = C-1 (floor -128), B += N, and if B is still <= -N, B = -N+1; else if B > 0, C = C+1 (ceiling 127), B -= N, and if B is still > 0, B = 0.
REQ-025 All arithmetic SHALL be done at full width and never wrap; A SHALL saturate at 2^A_W-1.
REQ-026 An in_q >= NUM_CTX SHALL be accepted, SHALL produce out_valid with all data outputs 0, and SHALL NOT modify storage.

Reset
REQ-027 While reset is 1, the block SHALL hold out_valid=0, in_ready=0, all out_* data=0 and empty both pipeline stages.
REQ-028 After reset is released, the FSM SHALL enter INIT at address 0; reset in any state, including mid-INIT or with requests in flight, SHALL discard in-flight requests and restart INIT.

Verification
REQ-029 The bench SHALL check: reset release -> in_ready=0 for exactly 365 cycles, then 1; q=0, err=0 -> 2 cycles later out_k=2, out_a=4, out_b=0, out_c=0, out_n=2.
REQ-030 The bench SHALL check: fresh q=10, err=+5 -> out_k=2, out_a=9, out_b=0, out_c=1, out_n=2.
REQ-031 The bench SHALL check: two back-to-back requests q=10, err=+5 from fresh -> second result out_k=3, out_a=14, out_b=0, out_c=2, out_n=3, proving forwarding.
REQ-032 The bench SHALL check: 64 consecutive requests q=3, err=0 -> 64th result out_a=2, out_n=33, out_b=0.
REQ-033 The bench SHALL check: 200 requests q=7, err=-100 -> out_c decrements by 1 per result, reaches -128 on the 128th result and holds -128 thereafter.
REQ-034 The bench SHALL check: reset for 1 cycle mid-stream with 2 requests in flight -> no out_valid for those requests, 365-cycle INIT repeats, q=10 err=0 then returns out_a=4, out_c=0, out_n=2.

Source files
------------

// File: rtl/context_update_stage.sv
// context_update_stage: per-context A/B/C/N statistics update for a
// LOCO-I style regular-mode coder, two-stage pipeline with forwarding.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (ready only once storage is initialised)
//   in_q, in_err       context index and signed prediction error
//   out_valid          one-cycle result strobe, two cycles after acceptance
//   out_q, out_k       echoed context index, Golomb k from pre-update A/N
//   out_a/b/c/n        post-update context values (all data 0 for bad index)
module context_update_stage #(
  parameter int unsigned NUM_CTX = 365,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned A_W     = 16,
  parameter int unsigned N_W     = 7,
  parameter int unsigned RESET_N = 64,
  parameter int unsigned A_INIT  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8:0]                     in_q,
  input  logic signed [ERR_W-1:0]        in_err,
  output logic                           out_valid,
  output logic [8:0]                     out_q,
  output logic [4:0]                     out_k,
  output logic [A_W-1:0]                 out_a,
  output logic signed [ERR_W+N_W-1:0]    out_b,
  output logic signed [7:0]              out_c,
  output logic [N_W-1:0]                 out_n
);

  localparam int unsigned Q_W  = 9;
  localparam int unsigned K_W  = 5;
  localparam int unsigned C_W  = 8;
  localparam int unsigned B_W  = ERR_W + N_W;
  localparam int unsigned AX_W = A_W + 2;
  localparam int unsigned BX_W = B_W + 3;
  localparam int unsigned NX_W = N_W + 1;
  localparam int unsigned KX_W = A_W + N_W + 1;

  localparam logic signed [C_W-1:0] C_MIN = {1'b1, {(C_W-1){1'b0}}};
  localparam logic signed [C_W-1:0] C_MAX = {1'b0, {(C_W-1){1'b1}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         state, state_nxt;
  logic [Q_W-1:0] init_addr, init_addr_nxt;

  // Context storage
  logic [A_W-1:0]        a_mem [NUM_CTX];
  logic signed [B_W-1:0] b_mem [NUM_CTX];
  logic signed [C_W-1:0] c_mem [NUM_CTX];
  logic [N_W-1:0]        n_mem [NUM_CTX];

  // Stage 1 registers
  logic                  s1_valid;
  logic                  s1_inrange;
  logic [Q_W-1:0]        s1_q;
  logic signed [ERR_W-1:0] s1_err;
  logic [A_W-1:0]        s1_a;
  logic signed [B_W-1:0] s1_b;
  logic signed [C_W-1:0] s1_c;
  logic [N_W-1:0]        s1_n;

  // Stage 2 combinational results
  logic [K_W-1:0]        upd_k_c;
  logic [A_W-1:0]        upd_a_c;
  logic signed [B_W-1:0] upd_b_c;
  logic signed [C_W-1:0] upd_c_c;
  logic [N_W-1:0]        upd_n_c;

  logic                  accept_c;
  logic                  in_inrange_c;
  logic [Q_W-1:0]        rd_idx_c;
  logic                  fwd_c;
  logic [A_W-1:0]        rd_a_c;
  logic signed [B_W-1:0] rd_b_c;
  logic signed [C_W-1:0] rd_c_c;
  logic [N_W-1:0]        rd_n_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
    end
  end

  // FSM next state: sweep every address once, then run
  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    case (state)
      ST_INIT: begin
        if (init_addr == Q_W'(NUM_CTX - 1)) begin
          state_nxt     = ST_RUN;
          init_addr_nxt = '0;
        end else begin
          init_addr_nxt = init_addr + Q_W'(1);
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Ready is registered from the next state so it rises with RUN
  always_ff @(posedge clk) begin
    if (reset) in_ready <= 1'b0;
    else       in_ready <= (state_nxt == ST_RUN);
  end

  assign accept_c     = in_valid && in_ready;
  assign in_inrange_c = (in_q < Q_W'(NUM_CTX));
  assign rd_idx_c     = in_inrange_c ? in_q : '0;

  // Forward the stage-2 result when it targets the context being read
  assign fwd_c  = s1_valid && s1_inrange && (s1_q == in_q);
  assign rd_a_c = fwd_c ? upd_a_c : a_mem[rd_idx_c];
  assign rd_b_c = fwd_c ? upd_b_c : b_mem[rd_idx_c];
  assign rd_c_c = fwd_c ? upd_c_c : c_mem[rd_idx_c];
  assign rd_n_c = fwd_c ? upd_n_c : n_mem[rd_idx_c];

  // Stage 1: capture request and its context
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_inrange <= 1'b0;
      s1_q       <= '0;
      s1_err     <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      s1_n       <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_q       <= in_q;
        s1_err     <= in_err;
        s1_inrange <= in_inrange_c;
        s1_a       <= rd_a_c;
        s1_b       <= rd_b_c;
        s1_c       <= rd_c_c;
        s1_n       <= rd_n_c;
      end
    end
  end

  // Stage 2: Golomb k and context update at widened precision
  logic signed [ERR_W:0]    err_x;
  logic [ERR_W:0]           abs_err;
  logic                     halve;
  logic [AX_W-1:0]          a_sum;
  logic [AX_W-1:0]          a_h;
  logic [NX_W-1:0]          n1;
  logic signed [BX_W-1:0]   nn;
  logic signed [BX_W-1:0]   b1;
  logic signed [BX_W-1:0]   b2;
  logic                     k_found;

  always_comb begin
    err_x   = (ERR_W+1)'(s1_err);
    abs_err = err_x[ERR_W] ? (ERR_W+1)'(-err_x) : (ERR_W+1)'(err_x);
    halve   = (s1_n == N_W'(RESET_N));

    a_sum   = AX_W'(s1_a) + AX_W'(abs_err);
    a_h     = halve ? (a_sum >> 1) : a_sum;
    upd_a_c = (|a_h[AX_W-1:A_W]) ? {A_W{1'b1}} : a_h[A_W-1:0];

    n1      = halve ? (NX_W'(s1_n >> 1) + NX_W'(1)) : (NX_W'(s1_n) + NX_W'(1));
    upd_n_c = N_W'(n1);
    nn      = $signed(BX_W'(n1));

    b1 = BX_W'(s1_b) + BX_W'(s1_err);
    if (halve) b1 = b1 >>> 1;

    // Bias correction against the new N
    upd_c_c = s1_c;
    b2      = b1;
    if (b1 <= -nn) begin
      upd_c_c = (s1_c == C_MIN) ? s1_c : s1_c - C_W'(1);
      b2      = b1 + nn;
      if (b2 <= -nn) b2 = BX_W'(1) - nn;
    end else if (b1 > 0) begin
      upd_c_c = (s1_c == C_MAX) ? s1_c : s1_c + C_W'(1);
      b2      = b1 - nn;
      if (b2 > 0) b2 = '0;
    end
    upd_b_c = B_W'(b2);

    // Smallest k with (N << k) >= A, pre-update values
    upd_k_c = K_W'(A_W);
    k_found = 1'b0;
    for (int unsigned i = 0; i <= A_W; i++) begin
      if (!k_found && ((KX_W'(s1_n) << i) >= KX_W'(s1_a))) begin
        upd_k_c = K_W'(i);
        k_found = 1'b1;
      end
    end
  end

  // Storage writes: initialisation sweep or stage-2 write-back
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        a_mem[init_addr] <= A_W'(A_INIT);
        b_mem[init_addr] <= '0;
        c_mem[init_addr] <= '0;
        n_mem[init_addr] <= N_W'(1);
      end else if (s1_valid && s1_inrange) begin
        a_mem[s1_q] <= upd_a_c;
        b_mem[s1_q] <= upd_b_c;
        c_mem[s1_q] <= upd_c_c;
        n_mem[s1_q] <= upd_n_c;
      end
    end
  end

  // Stage 2 output registers; out-of-range requests report all zeros
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_k     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_n     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid && s1_inrange) begin
        out_q <= s1_q;
        out_k <= upd_k_c;
        out_a <= upd_a_c;
        out_b <= upd_b_c;
        out_c <= upd_c_c;
        out_n <= upd_n_c;
      end else begin
        out_q <= '0;
        out_k <= '0;
        out_a <= '0;
        out_b <= '0;
        out_c <= '0;
        out_n <= '0;
      end
    end
  end

endmodule
